if_fetch: RTL and testbench

Instruction-fetch stage directly upstream of the decode stage. Owns the PC and reads each 32-bit instruction as four little-endian bytes over the byte-wide memory port. Presents {pc_o, inst_o} to the IF/ID register under ctrl stall control. Accepts branch/jump redirects resolved in decode (jump_i/jpc_i) and discards wrong-path fetches.

---
 rtl/if_fetch.sv | 158 +++++++++++++++
 tb/tb_if_fetch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction fetch stage. Assembles 32-bit little-endian words
//               from a byte-wide memory port and presents {pc, inst} to IF/ID.
//               Define IF_JUMP_ABORT_EN to abort in-flight fetches on redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jpc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_data_i,
    input  logic        mem_ack_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stall_req_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q,    pc_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic [31:0] inst_q,  inst_d;
`ifndef IF_JUMP_ABORT_EN
    logic        pend_q,  pend_d;
    logic [31:0] tgt_q,   tgt_d;
`endif

    logic [31:0] w_target;
    logic        w_redirect;

    // Redirect targets are always word aligned.
    assign w_target   = jpc_i & 32'hFFFF_FFFC;
    assign w_redirect = jump_i & ~stall_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        inst_d       = inst_q;
`ifndef IF_JUMP_ABORT_EN
        pend_d       = pend_q;
        tgt_d        = tgt_q;
`endif
        mem_req_o    = 1'b0;
        mem_addr_o   = 32'd0;
        pc_o         = 32'd0;
        inst_o       = 32'd0;
        inst_valid_o = 1'b0;
        stall_req_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                cnt_d   = 2'd0;
            end
            ST_FETCH: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = pc_q + {30'd0, cnt_q};
                stall_req_o = 1'b1;
`ifdef IF_JUMP_ABORT_EN
                if (w_redirect) begin
                    state_d = ST_ABORT;
                    pc_d    = w_target;
                    cnt_d   = 2'd0;
                end else if (mem_ack_i) begin
                    inst_d[{cnt_q, 3'b000} +: 8] = mem_data_i;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
`else
                if (w_redirect) begin
                    pend_d = 1'b1;
                    tgt_d  = w_target;
                end
                if (mem_ack_i) begin
                    inst_d[{cnt_q, 3'b000} +: 8] = mem_data_i;
                    if (cnt_q != 2'd3) begin
                        cnt_d = cnt_q + 2'd1;
                    end else if (w_redirect || pend_q) begin
                        // Wrong-path word: skip DONE and restart at the target.
                        pc_d   = w_redirect ? w_target : tgt_q;
                        pend_d = 1'b0;
                        cnt_d  = 2'd0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
`endif
            end
            ST_DONE: begin
                inst_valid_o = 1'b1;
                pc_o         = pc_q;
                inst_o       = inst_q;
                if (!stall_i) begin
                    state_d = ST_FETCH;
                    cnt_d   = 2'd0;
                    pc_d    = jump_i ? w_target : pc_q + 32'd4;
                end
            end
`ifdef IF_JUMP_ABORT_EN
            ST_ABORT: begin
                stall_req_o = 1'b1;
                state_d     = ST_FETCH;
                cnt_d       = 2'd0;
                if (w_redirect) begin
                    pc_d = w_target;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 2'd0;
            inst_q  <= 32'd0;
`ifndef IF_JUMP_ABORT_EN
            pend_q  <= 1'b0;
            tgt_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
`ifndef IF_JUMP_ABORT_EN
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Directed self-checking bench for if_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jpc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_data_i;
    logic        mem_ack_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stall_req_o;

    int checks;
    int failures;

    // Byte memory: mem[a] = a[7:0] + 8'h10, except 13 00 00 00 at 0..3.
    logic [7:0] mem [0:511];
    assign mem_data_i = mem[mem_addr_o[8:0]];

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .jump_i       (jump_i),
        .jpc_i        (jpc_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .stall_req_o  (stall_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_word();
        mem_ack_i = 1'b1;
        repeat (4) tick();
        mem_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({mem_req_o, stall_req_o, inst_valid_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000", {mem_req_o, stall_req_o, inst_valid_o});
        end
        checks++;
        if ({mem_addr_o, pc_o, inst_o} !== 96'd0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h pc=%h inst=%h expected all 0", mem_addr_o, pc_o, inst_o);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({mem_req_o, stall_req_o, mem_addr_o} !== {2'b11, 32'h0}) begin
            failures++;
            $display("FAIL reset_first_fetch: got req=%b sreq=%b addr=%h expected 1 1 0", mem_req_o, stall_req_o, mem_addr_o);
        end
    endtask

    task automatic test_basic_fetch();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_addr_o !== 32'(i)) begin
                failures++;
                $display("FAIL basic_addr%0d: got %h expected %h", i, mem_addr_o, i);
            end
            mem_ack_i = 1'b1;
            tick();
        end
        mem_ack_i = 1'b0;
        checks++;
        if ({inst_valid_o, mem_req_o, stall_req_o, pc_o, inst_o} !== {3'b100, 32'h0, 32'h0000_0013}) begin
            failures++;
            $display("FAIL basic_done: got v=%b req=%b sreq=%b pc=%h inst=%h expected 1 0 0 0 00000013",
                     inst_valid_o, mem_req_o, stall_req_o, pc_o, inst_o);
        end
        tick();
        checks++;
        if ({mem_req_o, inst_valid_o, mem_addr_o} !== {2'b10, 32'h4}) begin
            failures++;
            $display("FAIL basic_next: got req=%b v=%b addr=%h expected 1 0 4", mem_req_o, inst_valid_o, mem_addr_o);
        end
    endtask

    task automatic test_ack_gaps();
        for (int i = 0; i < 4; i++) begin
            mem_ack_i = 1'b0;
            tick();
            checks++;
            if ({mem_req_o, stall_req_o, inst_valid_o, mem_addr_o} !== {3'b110, 32'(4 + i)}) begin
                failures++;
                $display("FAIL gap_hold%0d: got req=%b sreq=%b v=%b addr=%h expected 1 1 0 %h",
                         i, mem_req_o, stall_req_o, inst_valid_o, mem_addr_o, 4 + i);
            end
            mem_ack_i = 1'b1;
            tick();
        end
        mem_ack_i = 1'b0;
        checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'h4, 32'h1716_1514}) begin
            failures++;
            $display("FAIL gap_done: got v=%b pc=%h inst=%h expected 1 4 17161514", inst_valid_o, pc_o, inst_o);
        end
    endtask

    task automatic test_stall_done();
        stall_i = 1'b1;
        jump_i  = 1'b1;
        jpc_i   = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({inst_valid_o, mem_req_o, stall_req_o, pc_o, inst_o} !== {3'b100, 32'h4, 32'h1716_1514}) begin
                failures++;
                $display("FAIL stall_hold%0d: got v=%b req=%b sreq=%b pc=%h inst=%h expected 1 0 0 4 17161514",
                         i, inst_valid_o, mem_req_o, stall_req_o, pc_o, inst_o);
            end
        end
        stall_i = 1'b0;
        jump_i  = 1'b0;
        tick();
        checks++;
        if ({mem_req_o, inst_valid_o, mem_addr_o} !== {2'b10, 32'h8}) begin
            failures++;
            $display("FAIL stall_release: got req=%b v=%b addr=%h expected 1 0 8", mem_req_o, inst_valid_o, mem_addr_o);
        end
    endtask

    task automatic test_jump_fetch();
        mem_ack_i = 1'b1;
        repeat (2) tick();
        mem_ack_i = 1'b0;
        jump_i    = 1'b1;
        jpc_i     = 32'h0000_0103;
        tick();
        jump_i    = 1'b0;
`ifdef IF_JUMP_ABORT_EN
        checks++;
        if ({mem_req_o, stall_req_o, inst_valid_o} !== 3'b010) begin
            failures++;
            $display("FAIL jump_abort_cycle: got req=%b sreq=%b v=%b expected 0 1 0", mem_req_o, stall_req_o, inst_valid_o);
        end
        tick();
`else
        checks++;
        if ({mem_req_o, inst_valid_o, mem_addr_o} !== {2'b10, 32'hA}) begin
            failures++;
            $display("FAIL jump_pend_byte2: got req=%b v=%b addr=%h expected 1 0 a", mem_req_o, inst_valid_o, mem_addr_o);
        end
        mem_ack_i = 1'b1;
        tick();
        checks++;
        if (mem_addr_o !== 32'hB) begin
            failures++;
            $display("FAIL jump_pend_byte3: got %h expected b", mem_addr_o);
        end
        tick();
        mem_ack_i = 1'b0;
`endif
        checks++;
        if ({mem_req_o, inst_valid_o, mem_addr_o} !== {2'b10, 32'h100}) begin
            failures++;
            $display("FAIL jump_target: got req=%b v=%b addr=%h expected 1 0 100", mem_req_o, inst_valid_o, mem_addr_o);
        end
        fetch_word();
        checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'h100, 32'h1312_1110}) begin
            failures++;
            $display("FAIL jump_word: got v=%b pc=%h inst=%h expected 1 100 13121110", inst_valid_o, pc_o, inst_o);
        end
    endtask

    task automatic test_jump_done_wrap();
        jump_i = 1'b1;
        jpc_i  = 32'hFFFF_FFFE;
        tick();
        jump_i = 1'b0;
        checks++;
        if ({mem_req_o, inst_valid_o, mem_addr_o} !== {2'b10, 32'hFFFF_FFFC}) begin
            failures++;
            $display("FAIL jump_done: got req=%b v=%b addr=%h expected 1 0 fffffffc", mem_req_o, inst_valid_o, mem_addr_o);
        end
        fetch_word();
        checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'hFFFF_FFFC, 32'h0F0E_0D0C}) begin
            failures++;
            $display("FAIL wrap_word: got v=%b pc=%h inst=%h expected 1 fffffffc 0f0e0d0c", inst_valid_o, pc_o, inst_o);
        end
        tick();
        checks++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL wrap_next: got req=%b addr=%h expected 1 0", mem_req_o, mem_addr_o);
        end
    endtask

    task automatic test_reset_mid_fetch();
        mem_ack_i = 1'b1;
        repeat (2) tick();
        mem_ack_i = 1'b0;
        checks++;
        if (mem_addr_o !== 32'h2) begin
            failures++;
            $display("FAIL midrst_pre: got %h expected 2", mem_addr_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({mem_req_o, stall_req_o, inst_valid_o, mem_addr_o, pc_o, inst_o} !== 99'd0) begin
            failures++;
            $display("FAIL midrst_outputs: got req=%b sreq=%b v=%b addr=%h pc=%h inst=%h expected all 0",
                     mem_req_o, stall_req_o, inst_valid_o, mem_addr_o, pc_o, inst_o);
        end
        tick();
        checks++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL midrst_restart: got req=%b addr=%h expected 1 0", mem_req_o, mem_addr_o);
        end
        fetch_word();
        checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'h0, 32'h0000_0013}) begin
            failures++;
            $display("FAIL midrst_word: got v=%b pc=%h inst=%h expected 1 0 00000013", inst_valid_o, pc_o, inst_o);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        stall_i   = 1'b0;
        jump_i    = 1'b0;
        jpc_i     = 32'd0;
        mem_ack_i = 1'b0;
        for (int a = 0; a < 512; a++) begin
            mem[a] = 8'(a) + 8'h10;
        end
        mem[0] = 8'h13;
        mem[1] = 8'h00;
        mem[2] = 8'h00;
        mem[3] = 8'h00;

        test_reset();
        test_basic_fetch();
        test_ack_gaps();
        test_stall_done();
        test_jump_fetch();
        test_jump_done_wrap();
        test_reset_mid_fetch();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
